// File: rtl/vc_arbiter_pkg.sv
// vc_arbiter_pkg: shared state encoding, error-vector layout and default
// sizing for the virtual-channel arbiter slice.
package vc_arbiter_pkg;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } arb_state_t;

  // Error vector layout {MF, VC0, VC1, D0, D1}
  localparam int ERR_W   = 5;
  localparam int ERR_MF  = 4;
  localparam int ERR_VC0 = 3;
  localparam int ERR_VC1 = 2;
  localparam int ERR_D0  = 1;
  localparam int ERR_D1  = 0;

  localparam int DEF_DATA_W     = 6;
  localparam int DEF_DEST_BIT   = 4;
  localparam int DEF_MAX_STARVE = 4;

  // Any flagged FIFO error halts arbitration.
  function automatic logic fifo_error(input logic [ERR_W-1:0] err);
    return err[ERR_MF] | err[ERR_VC0] | err[ERR_VC1] | err[ERR_D0] | err[ERR_D1];
  endfunction

endpackage

// File: rtl/vc_arbiter_if.sv
// vc_arbiter_if: FIFO-side bundle of the arbiter. The master modport is the
// arbiter (pops VCs, pushes Ds); the slave modport is the FIFO side.
interface vc_arbiter_if
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              vc0_empty;
  logic              vc1_empty;
  logic [DATA_W-1:0] vc0_data;
  logic [DATA_W-1:0] vc1_data;
  logic              d0_almost_full;
  logic              d1_almost_full;
  logic              vc0_pop;
  logic              vc1_pop;
  logic              d0_push;
  logic              d1_push;
  logic [DATA_W-1:0] d0_data;
  logic [DATA_W-1:0] d1_data;

  modport master (
    input  vc0_empty, vc1_empty, vc0_data, vc1_data,
    input  d0_almost_full, d1_almost_full,
    output vc0_pop, vc1_pop,
    output d0_push, d1_push, d0_data, d1_data
  );

  modport slave (
    output vc0_empty, vc1_empty, vc0_data, vc1_data,
    output d0_almost_full, d1_almost_full,
    input  vc0_pop, vc1_pop,
    input  d0_push, d1_push, d0_data, d1_data
  );

endinterface

// File: rtl/vc_arb_grant.sv
// vc_arb_grant: per-channel eligibility, VC0-priority grant with a
// starvation escape for VC1, and the starvation counter.
module vc_arb_grant
  import vc_arbiter_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic vc0_empty,
  input  logic vc1_empty,
  input  logic vc0_dest,
  input  logic vc1_dest,
  input  logic d0_almost_full,
  input  logic d1_almost_full,
  output logic grant0,
  output logic grant1
);

  localparam logic [3:0] STARVE_LIMIT = 4'(MAX_STARVE);

  logic [3:0] starve_cnt;
  logic       elig0;
  logic       elig1;
  logic       starve_hit;

  // A channel is eligible when its head word's destination has room; a
  // blocked VC0 head therefore never holds up an eligible VC1.
  always_comb begin
    elig0      = run && !vc0_empty && !(vc0_dest ? d1_almost_full : d0_almost_full);
    elig1      = run && !vc1_empty && !(vc1_dest ? d1_almost_full : d0_almost_full);
    starve_hit = (starve_cnt == STARVE_LIMIT);
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (elig0 && elig1) begin
      grant1 = starve_hit;
      grant0 = !starve_hit;
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  // Count VC0 wins over a waiting VC1; reset once VC1 is served or drains.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= 4'd0;
    end else if (vc1_empty || grant1) begin
      starve_cnt <= 4'd0;
    end else if (grant0 && elig1 && (starve_cnt < STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/vc_arbiter.sv
// vc_arbiter: moves words from VC0/VC1 into D0/D1, routing on one word bit.
// Pops are combinational in the grant cycle; pushes follow one cycle later.
module vc_arbiter
  import vc_arbiter_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEST_BIT   = DEF_DEST_BIT,
  parameter int MAX_STARVE = DEF_MAX_STARVE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active_in,
  input  logic [ERR_W-1:0] error_in,
  vc_arbiter_if.master     bus,
  output logic             idle_out
);

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              run;
  logic              grant0;
  logic              grant1;
  logic              any_pop;
  logic [DATA_W-1:0] sel_word;
  logic              sel_dest;
  logic              d0_push_q;
  logic              d1_push_q;
  logic [DATA_W-1:0] d0_data_q;
  logic [DATA_W-1:0] d1_data_q;

  // Run/halt state register; a change of enable or error lands a cycle later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= HALT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode from the control FSM enable and the FIFO error vector.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HALT: if (active_in && !fifo_error(error_in)) state_d = RUN;
      RUN:  if (!active_in || fifo_error(error_in)) state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  assign run = reset && (state_q == RUN);

  vc_arb_grant #(
    .MAX_STARVE (MAX_STARVE)
  ) u_grant (
    .clk            (clk),
    .reset          (reset),
    .run            (run),
    .vc0_empty      (bus.vc0_empty),
    .vc1_empty      (bus.vc1_empty),
    .vc0_dest       (bus.vc0_data[DEST_BIT]),
    .vc1_dest       (bus.vc1_data[DEST_BIT]),
    .d0_almost_full (bus.d0_almost_full),
    .d1_almost_full (bus.d1_almost_full),
    .grant0         (grant0),
    .grant1         (grant1)
  );

  // Select the granted head word and its destination.
  always_comb begin
    any_pop  = grant0 || grant1;
    sel_word = grant1 ? bus.vc1_data : bus.vc0_data;
    sel_dest = sel_word[DEST_BIT];
  end

  // Output pipeline: register the popped word into its destination; data
  // holds between pushes and only the strobes qualify it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      d0_push_q <= 1'b0;
      d1_push_q <= 1'b0;
      d0_data_q <= '0;
      d1_data_q <= '0;
    end else begin
      d0_push_q <= any_pop && !sel_dest;
      d1_push_q <= any_pop && sel_dest;
      if (any_pop && !sel_dest) d0_data_q <= sel_word;
      if (any_pop && sel_dest)  d1_data_q <= sel_word;
    end
  end

  // Idle when both channels are drained and nothing is being pushed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idle_out <= 1'b1;
    end else begin
      idle_out <= bus.vc0_empty && bus.vc1_empty && !d0_push_q && !d1_push_q;
    end
  end

  assign bus.vc0_pop = grant0;
  assign bus.vc1_pop = grant1;
  assign bus.d0_push = d0_push_q;
  assign bus.d1_push = d1_push_q;
  assign bus.d0_data = d0_data_q;
  assign bus.d1_data = d1_data_q;

endmodule

// File: tb/tb_vc_arbiter.sv
// tb_vc_arbiter: directed scenarios with a push scoreboard; the monitor pops
// and compares expected {dest, word} on every D push.
module tb_vc_arbiter;
  import vc_arbiter_pkg::*;

  localparam int DATA_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             active_in;
  logic [ERR_W-1:0] error_in;
  logic             idle_out;

  vc_arbiter_if #(.DATA_W(DATA_W)) bus ();

  vc_arbiter #(
    .DATA_W     (DATA_W),
    .DEST_BIT   (4),
    .MAX_STARVE (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .active_in (active_in),
    .error_in  (error_in),
    .bus       (bus),
    .idle_out  (idle_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              dest;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t              sb[$];
  logic [DATA_W-1:0] q0[$];
  logic [DATA_W-1:0] q1[$];
  int                grant_log[$];
  int                checks = 0;
  int                errors = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic act, input logic [ERR_W-1:0] err,
                               input logic af0, input logic af1);
    active_in          = act;
    error_in           = err;
    bus.d0_almost_full = af0;
    bus.d1_almost_full = af1;
  endtask

  task automatic drive_heads();
    bus.vc0_empty = (q0.size() == 0);
    bus.vc1_empty = (q1.size() == 0);
    bus.vc0_data  = (q0.size() == 0) ? '0 : q0[0];
    bus.vc1_data  = (q1.size() == 0) ? '0 : q1[0];
  endtask

  task automatic load_vc(input int ch, input logic [DATA_W-1:0] w);
    if (ch == 0) q0.push_back(w);
    else         q1.push_back(w);
    drive_heads();
  endtask

  task automatic expect_push(input logic dest, input logic [DATA_W-1:0] w);
    exp_t e;
    e.dest = dest;
    e.data = w;
    sb.push_back(e);
  endtask

  // One clock: sample pops mid-cycle, then retire them from the FIFO model.
  task automatic tick();
    logic p0, p1;
    int   n0, n1;
    @(negedge clk);
    p0 = bus.vc0_pop;
    p1 = bus.vc1_pop;
    n0 = q0.size();
    n1 = q1.size();
    if (p0 || p1) begin
      checkOutput("single_grant", int'(p0 && p1), 0);
      checkOutput("pop_nonempty", int'((p0 && n0 == 0) || (p1 && n1 == 0)), 0);
    end
    if (p0) grant_log.push_back(0);
    if (p1) grant_log.push_back(1);
    @(posedge clk);
    #1;
    if (p0 && n0 > 0) void'(q0.pop_front());
    if (p1 && n1 > 0) void'(q1.pop_front());
    drive_heads();
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (i < budget && (sb.size() != 0 || q0.size() != 0 || q1.size() != 0)) begin
      tick();
      i++;
    end
    checkOutput("drain_sb_left", sb.size(), 0);
  endtask

  // Scoreboard monitor: every push must match the next expected word.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (bus.d0_push || bus.d1_push) begin
      got.dest = bus.d1_push;
      got.data = bus.d1_push ? bus.d1_data : bus.d0_data;
      checkOutput("one_push", int'(bus.d0_push && bus.d1_push), 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_push actual=d%0d/%0h expected=none",
                 got.dest, got.data);
      end else begin
        want = sb.pop_front();
        checkOutput("push_dest", int'(got.dest), int'(want.dest));
        checkOutput("push_data", int'(got.data), int'(want.data));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp_g[10];
    exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

    reset = 1'b0;
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0);
    drive_heads();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_d0_push", int'(bus.d0_push), 0);
    checkOutput("rst_d1_push", int'(bus.d1_push), 0);
    checkOutput("rst_d0_data", int'(bus.d0_data), 0);
    checkOutput("rst_d1_data", int'(bus.d1_data), 0);
    checkOutput("rst_idle", int'(idle_out), 1);
    reset = 1'b1;

    $display("[TB] both VCs empty while active");
    applyStimulus(1'b1, 5'b0, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("empty_no_grants", grant_log.size(), 0);
    checkOutput("empty_idle", int'(idle_out), 1);

    $display("[TB] VC0 three words, routed by bit 4");
    grant_log.delete();
    expect_push(1'b0, 6'h05);
    expect_push(1'b1, 6'h15);
    expect_push(1'b0, 6'h03);
    load_vc(0, 6'h05);
    load_vc(0, 6'h15);
    load_vc(0, 6'h03);
    tick();
    checkOutput("stream_idle_low", int'(idle_out), 0);
    repeat (3) tick();
    checkOutput("stream_latency", sb.size(), 0);
    checkOutput("stream_grants", grant_log.size(), 3);
    drain(10);

    $display("[TB] starvation escape for VC1");
    grant_log.delete();
    for (int i = 1; i <= 4; i++) expect_push(1'b0, 6'(i));
    expect_push(1'b0, 6'h20);
    for (int i = 5; i <= 8; i++) expect_push(1'b0, 6'(i));
    expect_push(1'b0, 6'h21);
    for (int i = 1; i <= 8; i++) load_vc(0, 6'(i));
    load_vc(1, 6'h20);
    load_vc(1, 6'h21);
    drain(30);
    checkOutput("starve_grant_count", grant_log.size(), 10);
    for (int i = 0; i < 10 && i < grant_log.size(); i++)
      checkOutput($sformatf("starve_grant_%0d", i), grant_log[i], exp_g[i]);

    $display("[TB] blocked VC0 head bypassed by VC1");
    grant_log.delete();
    applyStimulus(1'b1, 5'b0, 1'b0, 1'b1);
    expect_push(1'b0, 6'h01);
    expect_push(1'b1, 6'h12);
    load_vc(0, 6'h12);
    load_vc(1, 6'h01);
    repeat (3) tick();
    checkOutput("bypass_vc0_held", q0.size(), 1);
    checkOutput("bypass_vc1_done", sb.size(), 1);
    checkOutput("bypass_first_grant", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    applyStimulus(1'b1, 5'b0, 1'b0, 1'b0);
    drain(10);

    $display("[TB] error halt and resume");
    for (int i = 1; i <= 6; i++) begin
      expect_push(1'b0, 6'(i));
      load_vc(0, 6'(i));
    end
    repeat (2) tick();
    applyStimulus(1'b1, 5'b00010, 1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("err_halt_depth", q0.size(), 3);
    checkOutput("err_last_pushed", sb.size(), 3);
    applyStimulus(1'b1, 5'b0, 1'b0, 1'b0);
    tick();
    checkOutput("err_resume_delay", q0.size(), 3);
    tick();
    checkOutput("err_resume_pop", q0.size(), 2);
    drain(10);

    $display("[TB] reset mid-stream");
    expect_push(1'b0, 6'h07);
    load_vc(0, 6'h07);
    load_vc(0, 6'h08);
    load_vc(0, 6'h09);
    load_vc(0, 6'h0A);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, 5'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    checkOutput("midrst_d0_push", int'(bus.d0_push), 0);
    checkOutput("midrst_d1_push", int'(bus.d1_push), 0);
    checkOutput("midrst_d0_data", int'(bus.d0_data), 0);
    checkOutput("midrst_idle", int'(idle_out), 1);
    repeat (3) tick();
    checkOutput("midrst_halted_depth", q0.size(), 3);
    expect_push(1'b0, 6'h08);
    expect_push(1'b0, 6'h09);
    expect_push(1'b0, 6'h0A);
    applyStimulus(1'b1, 5'b0, 1'b0, 1'b0);
    drain(10);
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
